// File: rtl/iqmod_pkg.sv
// Shared definitions for the I/Q modulator datapath: nibble width, idle
// sample value and the FT245R read-sequencer state encoding.
package iqmod_pkg;

   localparam int IQ_W = 4;
   localparam int BYTE_W = 2 * IQ_W;

   localparam logic [BYTE_W-1:0] IQ_IDLE_DEF = 8'h88;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_LOW  = 2'd1,
      RD_HIGH = 2'd2
   } rd_state_t;

   function automatic logic [IQ_W-1:0] hi_nibble(input logic [BYTE_W-1:0] b);
      return b[BYTE_W-1:IQ_W];
   endfunction

   function automatic logic [IQ_W-1:0] lo_nibble(input logic [BYTE_W-1:0] b);
      return b[IQ_W-1:0];
   endfunction

endpackage

// File: rtl/iq_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy; dout always shows the
// head entry so a pop and its data use the same edge.
module iq_byte_fifo
   import iqmod_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [BYTE_W-1:0]  din,
   output logic [BYTE_W-1:0]  dout,
   output logic [FIFO_AW:0]   level,
   output logic               full,
   output logic               empty
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
   localparam logic [FIFO_AW:0]   LVL_FULL = DEPTH;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

   logic [BYTE_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ft245r_iq_loader.sv
// Reads bytes from an FT245R receive FIFO, buffers them, and releases them
// as 4-bit I/Q samples at a fixed rate for the modulator core.
module ft245r_iq_loader
   import iqmod_pkg::*;
#(
   parameter int                RD_LOW_CYC  = 4,
   parameter int                RD_HIGH_CYC = 4,
   parameter int                FIFO_AW     = 4,
   parameter int                SAMPLE_DIV  = 1000,
   parameter logic [BYTE_W-1:0] IQ_IDLE     = IQ_IDLE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] usb_bus,
   input  logic              usb_rxf_,
   output logic              usb_rd_,
   output logic              usb_wr,
   output logic [IQ_W-1:0]   i,
   output logic [IQ_W-1:0]   q,
   output logic              sample_stb,
   output logic [FIFO_AW:0]  fifo_level,
   output logic              underrun
);

   localparam int PH_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
   localparam int PH_W   = $clog2(PH_MAX);
   localparam int DIV_W  = $clog2(SAMPLE_DIV);

   localparam logic [PH_W-1:0]  PH_ONE    = 1;
   localparam logic [PH_W-1:0]  LOW_LAST  = PH_W'(RD_LOW_CYC - 1);
   localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(RD_HIGH_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);

   rd_state_t         state;
   logic [PH_W-1:0]   ph_cnt;
   logic              rxf_meta;
   logic              rxf_s;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic              push;
   logic              pop;
   logic [BYTE_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;

   assign usb_wr = 1'b0;

   // RXF# is asynchronous; inverted here so rxf_s is active-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxf_meta <= 1'b0;
         rxf_s    <= 1'b0;
      end else begin
         rxf_meta <= ~usb_rxf_;
         rxf_s    <= rxf_meta;
      end
   end

   // A read, once started, always runs to completion; full is only
   // consulted in IDLE, and only pops can happen while RD# is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ph_cnt  <= '0;
         usb_rd_ <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (rxf_s && !fifo_full) begin
                  state   <= RD_LOW;
                  ph_cnt  <= '0;
                  usb_rd_ <= 1'b0;
               end
            end
            RD_LOW: begin
               if (ph_cnt == LOW_LAST) begin
                  state   <= RD_HIGH;
                  ph_cnt  <= '0;
                  usb_rd_ <= 1'b1;
               end else begin
                  ph_cnt <= ph_cnt + PH_ONE;
               end
            end
            RD_HIGH: begin
               if (ph_cnt == HIGH_LAST) begin
                  state  <= IDLE;
                  ph_cnt <= '0;
               end else begin
                  ph_cnt <= ph_cnt + PH_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               ph_cnt  <= '0;
               usb_rd_ <= 1'b1;
            end
         endcase
      end
   end

   assign push = (state == RD_LOW) && (ph_cnt == LOW_LAST);

   always_ff @(posedge clk) begin
      if (rst) div_cnt <= '0;
      else     div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
   end

   assign tick = (div_cnt == DIV_LAST);
   assign pop  = tick && !fifo_empty;

   // On an empty tick the outputs hold their last sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         i          <= hi_nibble(IQ_IDLE);
         q          <= lo_nibble(IQ_IDLE);
         sample_stb <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         sample_stb <= pop;
         if (pop) begin
            i <= hi_nibble(fifo_dout);
            q <= lo_nibble(fifo_dout);
         end
         if (tick && fifo_empty) underrun <= 1'b1;
      end
   end

   iq_byte_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (usb_bus),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: doc/ft245r_iq_loader.md
Name: ft245r_iq_loader

Overview:
Upstream feeder for the I/Q modulator core. It reads bytes from the FT245R USB FIFO using the RD#/RXF# handshake and buffers them in a small on-chip FIFO. Buffered samples are released at a fixed sample rate as 4-bit I and 4-bit Q values that drive the modulator's i/q inputs. It replaces the free-running tone generator as the source of i/q in the modulator top level.

Parameters:
RD_LOW_CYC, 4, clk cycles usb_rd_ is held low per byte (80 ns at 50 MHz; minimum 2).
RD_HIGH_CYC, 4, clk cycles usb_rd_ is held high after each byte before RXF# is looked at again (minimum 2).
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.
SAMPLE_DIV, 1000, clk cycles per output sample (50 kS/s at 50 MHz); minimum 2.
IQ_IDLE, 8'h88, {i,q} value driven after reset.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous reset, active-high.
usb_bus  in  8  FT245R data bus.
usb_rxf_  in  1  FT245R RXF#, active-low "data available"; asynchronous to clk.
usb_rd_  out  1  FT245R RD#, active-low read strobe.
usb_wr  out  1  FT245R WR; this block never transmits, so it is tied to 0.
i  out  4  in-phase sample to the modulator.
q  out  4  quadrature sample to the modulator.
sample_stb  out  1  one-cycle pulse when i/q load a new FIFO byte.
fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
underrun  out  1  sticky flag; set when a sample tick finds the FIFO empty.

Behaviour:
- Reset is checked at every clk edge and overrides everything else.
- Reset values: usb_rd_=1, usb_wr=0, {i,q}=IQ_IDLE, sample_stb=0, fifo_level=0, underrun=0. Reset also clears the FSM (IDLE), all counters and the FIFO pointers.
- Reset asserted during an active read: usb_rd_ returns high on the next edge and the partial byte is discarded.
- usb_rxf_ passes through a 2-flop synchroniser; rxf_s denotes the synchronised, active-high "data available".
- Read FSM states and transitions:
  - IDLE: if rxf_s=1 and the FIFO is not full, go to RD_LOW; usb_rd_ goes low on that same edge.
  - RD_LOW: hold usb_rd_=0 for exactly RD_LOW_CYC cycles. On the final RD_LOW edge, capture usb_bus and push it into the FIFO, drive usb_rd_=1, and go to RD_HIGH.
  - RD_HIGH: hold usb_rd_=1 for RD_HIGH_CYC cycles and ignore rxf_s, which is stale during precharge; then go to IDLE.
- Latency: from an RXF# pin edge to usb_rd_ low is 3 clk cycles (2 synchroniser cycles plus 1 IDLE decision cycle).
- Maximum read throughput is one byte per RD_LOW_CYC+RD_HIGH_CYC+1 cycles.
- Full handling: the FIFO-full check is made only in IDLE. A started read is always completed. Because only pops can occur during a read, the push can never overflow.
- Byte format: byte[7:4] becomes i and byte[3:0] becomes q.
- Sample timing: the divider counts 0..SAMPLE_DIV-1 and wraps. The tick fires when the count equals SAMPLE_DIV-1.
  - Tick with FIFO non-empty: pop the head byte; {i,q} take it on the same edge; sample_stb=1 for the following cycle.
  - Tick with FIFO empty: {i,q} hold their last value, sample_stb stays 0, underrun is set. underrun clears only on reset.
- Push and pop on the same edge: fifo_level is unchanged and data ordering is preserved.
- A push into an empty FIFO is poppable from the next edge onward (no fall-through on the push edge).
- fifo_level is registered. It updates on the same edge as the push or pop.
- The FIFO pointers wrap modulo 2**FIFO_AW. full is level==2**FIFO_AW; empty is level==0.

Decomposition:
- Shared package iqmod_pkg holds:
  - the FSM state enum (IDLE, RD_LOW, RD_HIGH);
  - the IQ_IDLE default;
  - the I/Q nibble width constant (4), which is shared with the modulator core.
- One sub-module, iq_byte_fifo: a synchronous single-clock FIFO, 8 bits wide with depth 2**FIFO_AW. It has push/pop/din/dout/level ports and synchronous active-high reset. The loader instantiates it; the FSM and the sample divider stay in the top.

Test Plan:
- Reset release with usb_rxf_=1: usb_rd_ stays 1, {i,q}=8/8. With SAMPLE_DIV=8, underrun=1 from cycle 8 onward and sample_stb is never asserted.
- Single byte: drive usb_bus=8'hF7 and pull usb_rxf_ low.
  - usb_rd_ falls 3 cycles later and stays low for exactly 4 cycles; fifo_level goes 0→1.
  - At the next tick, i=15, q=7, with a single sample_stb pulse.
- Burst of 20 bytes, 8'h00..8'h13, with RXF# held low and SAMPLE_DIV=1000:
  - fifo_level reaches 16, then usb_rd_ stays high while RXF# is still low.
  - Subsequent ticks output the bytes in order; reads resume once the level drops below 16.
- Simultaneous push and pop: align a read's final RD_LOW edge with a sample tick at level 3. Required: level stays 3 and the popped value is the oldest byte.
- Reset mid-read: assert rst on the 2nd RD_LOW cycle. Required: usb_rd_=1 on the next edge, fifo_level=0, and no byte is pushed.
- Minimum timing: RD_LOW_CYC=2, RD_HIGH_CYC=2 with RXF# held low. Required: usb_rd_ period is exactly 5 cycles (2 low, 3 high) and each low pulse captures one byte.
